ps2_direction_decoder: RTL and testbench

Converts a PS/2 keyboard (scan code set 2) into the one-hot `direction` and `fire` controls consumed by the player-plane block. It receives and checks PS/2 serial frames, then tracks make/break/extended sequences for WASD, the arrow keys and Space. It holds a per-key pressed state and produces a registered one-hot movement command in the system `clk` domain.

---
 rtl/ps2_keys_pkg.sv | 83 ++++++++
 rtl/ps2_rx.sv | 116 +++++++++++
 rtl/ps2_direction_decoder.sv | 138 +++++++++++++
 tb/tb_ps2_direction_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keys_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ps2_keys_pkg : scan codes, direction encodings and decoder states |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
package ps2_keys_pkg;

  localparam logic [7:0] c_sc_e0    = 8'hE0;
  localparam logic [7:0] c_sc_f0    = 8'hF0;
  localparam logic [7:0] c_sc_w     = 8'h1D;
  localparam logic [7:0] c_sc_s     = 8'h1B;
  localparam logic [7:0] c_sc_a     = 8'h1C;
  localparam logic [7:0] c_sc_d     = 8'h23;
  localparam logic [7:0] c_sc_space = 8'h29;
  localparam logic [7:0] c_sc_up    = 8'h75;
  localparam logic [7:0] c_sc_down  = 8'h72;
  localparam logic [7:0] c_sc_left  = 8'h6B;
  localparam logic [7:0] c_sc_right = 8'h74;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  // Bit positions inside the held register.
  localparam int         c_num_keys  = 9;
  localparam logic [3:0] c_key_w     = 4'd0;
  localparam logic [3:0] c_key_s     = 4'd1;
  localparam logic [3:0] c_key_a     = 4'd2;
  localparam logic [3:0] c_key_d     = 4'd3;
  localparam logic [3:0] c_key_up    = 4'd4;
  localparam logic [3:0] c_key_down  = 4'd5;
  localparam logic [3:0] c_key_left  = 4'd6;
  localparam logic [3:0] c_key_right = 4'd7;
  localparam logic [3:0] c_key_space = 4'd8;
  localparam logic [3:0] c_key_none  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  function automatic logic [3:0] key_index(input logic [7:0] code, input logic ext);
    logic [3:0] idx;
    idx = c_key_none;
    if (!ext) begin
      case (code)
        c_sc_w:     idx = c_key_w;
        c_sc_s:     idx = c_key_s;
        c_sc_a:     idx = c_key_a;
        c_sc_d:     idx = c_key_d;
        c_sc_space: idx = c_key_space;
        default:    idx = c_key_none;
      endcase
    end else begin
      case (code)
        c_sc_up:    idx = c_key_up;
        c_sc_down:  idx = c_key_down;
        c_sc_left:  idx = c_key_left;
        c_sc_right: idx = c_key_right;
        default:    idx = c_key_none;
      endcase
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_dir(input logic [3:0] idx);
    logic [3:0] dir;
    case (idx)
      c_key_w, c_key_up:       dir = DIR_UP;
      c_key_s, c_key_down:     dir = DIR_DOWN;
      c_key_a, c_key_left:     dir = DIR_LEFT;
      c_key_d, c_key_right:    dir = DIR_RIGHT;
      default:                 dir = DIR_NONE;
    endcase
    return dir;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ps2_rx : PS/2 synchroniser, clock filter, frame receiver, timeout |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] c_filt_last = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] c_to_last   = TW'(TIMEOUT_CYCLES);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic [FW-1:0] r_filt_cnt;
  logic          r_filt_clk;
  logic          r_filt_clk_d;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          w_fall;
  logic          w_din;

  assign w_fall = r_filt_clk_d & ~r_filt_clk;
  assign w_din  = r_dat_sync[1];

  // The filtered clock only follows the synchronised clock after a full run of equal samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync   <= 2'b11;
      r_dat_sync   <= 2'b11;
      r_filt_cnt   <= '0;
      r_filt_clk   <= 1'b1;
      r_filt_clk_d <= 1'b1;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], ps2_data};
      r_filt_clk_d <= r_filt_clk;
      if (r_clk_sync[1] == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_filt_last) begin
        r_filt_clk <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_bit_cnt)
          4'd0: begin
            if (w_din) begin
              frame_err <= 1'b1;
            end else begin
              r_bit_cnt <= 4'd1;
              r_parity  <= 1'b0;
            end
          end
          4'd10: begin
            r_bit_cnt <= 4'd0;
            // r_parity accumulates data and parity bits, so odd parity leaves it set.
            if (r_parity && w_din) begin
              rx_valid <= 1'b1;
              rx_byte  <= r_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            r_parity  <= r_parity ^ w_din;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt <= 4'd8) begin
              r_shift <= {w_din, r_shift[7:1]};
            end
          end
        endcase
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == c_to_last) begin
          frame_err <= 1'b1;
          r_bit_cnt <= 4'd0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_direction_decoder.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ps2_direction_decoder : PS/2 keys to one-hot direction and fire   |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module ps2_direction_decoder
  import ps2_keys_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] direction,
  output logic       fire,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  logic                  w_rx_valid;
  logic [7:0]            w_rx_byte;
  logic                  w_frame_err;
  dec_state_t            r_state;
  dec_state_t            w_state_nx;
  logic [c_num_keys-1:0] r_held;
  logic [c_num_keys-1:0] w_held_nx;
  logic [c_num_keys-1:0] w_key_mask;
  logic [3:0]            r_last_dir;
  logic [3:0]            w_last_nx;
  logic [3:0]            w_key;
  logic [3:0]            w_dh;
  logic [3:0]            w_dir_nx;
  logic                  w_is_make;
  logic                  w_is_brk;
  logic                  w_ext;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_valid  (w_rx_valid),
    .rx_byte   (w_rx_byte),
    .frame_err (w_frame_err)
  );

  assign rx_valid  = w_rx_valid;
  assign rx_byte   = w_rx_byte;
  assign frame_err = w_frame_err;

  always_comb begin
    w_state_nx = r_state;
    w_is_make  = 1'b0;
    w_is_brk   = 1'b0;
    w_ext      = 1'b0;
    if (w_frame_err) begin
      w_state_nx = ST_IDLE;
    end else if (w_rx_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rx_byte == c_sc_e0)      w_state_nx = ST_EXT;
          else if (w_rx_byte == c_sc_f0) w_state_nx = ST_BRK;
          else                           w_is_make  = 1'b1;
        end
        ST_EXT: begin
          if (w_rx_byte == c_sc_f0)      w_state_nx = ST_EXT_BRK;
          else if (w_rx_byte == c_sc_e0) w_state_nx = ST_EXT;
          else begin
            w_is_make  = 1'b1;
            w_ext      = 1'b1;
            w_state_nx = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_is_brk   = 1'b1;
          w_state_nx = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_is_brk   = 1'b1;
          w_ext      = 1'b1;
          w_state_nx = ST_IDLE;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_key      = key_index(w_rx_byte, w_ext);
    w_key_mask = (w_key == c_key_none) ? '0 : (c_num_keys'(1) << w_key);
    w_held_nx  = r_held;
    w_last_nx  = r_last_dir;
    if (w_is_make) begin
      w_held_nx = r_held | w_key_mask;
      // Repeats of a held key still move the last-pressed marker.
      if (key_dir(w_key) != DIR_NONE) w_last_nx = key_dir(w_key);
    end else if (w_is_brk) begin
      w_held_nx = r_held & ~w_key_mask;
    end
  end

  always_comb begin
    w_dh[0] = w_held_nx[c_key_w] | w_held_nx[c_key_up];
    w_dh[1] = w_held_nx[c_key_s] | w_held_nx[c_key_down];
    w_dh[2] = w_held_nx[c_key_a] | w_held_nx[c_key_left];
    w_dh[3] = w_held_nx[c_key_d] | w_held_nx[c_key_right];
    if ((w_last_nx & w_dh) != 4'b0000) w_dir_nx = w_last_nx;
    else if (w_dh[0])                  w_dir_nx = DIR_UP;
    else if (w_dh[1])                  w_dir_nx = DIR_DOWN;
    else if (w_dh[2])                  w_dir_nx = DIR_LEFT;
    else if (w_dh[3])                  w_dir_nx = DIR_RIGHT;
    else                               w_dir_nx = DIR_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_held     <= '0;
      r_last_dir <= DIR_NONE;
      direction  <= DIR_NONE;
      fire       <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_held     <= w_held_nx;
      r_last_dir <= w_last_nx;
      direction  <= w_dir_nx;
      fire       <= w_held_nx[c_key_space];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_direction_decoder.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_ps2_direction_decoder : randomised bench with key-state model  |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ps2_direction_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] direction;
  logic       fire;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_direction_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .direction (direction),
    .fire      (fire),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  int         n_vec = 0;
  int         n_miscmp = 0;
  int         n_valid = 0;
  int         n_err = 0;
  logic [7:0] last_byte = 8'h00;
  bit         multihot = 1'b0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      last_byte = rx_byte;
    end
    if (frame_err === 1'b1) n_err++;
    if (!rst && $countones(direction) > 1) multihot = 1'b1;
  end

  // Reference: key table, pressed set, last direction pressed, pending prefixes.
  logic [7:0] k_code[9] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74};
  bit         k_ext[9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
  int         k_dir[9]  = '{0, 1, 2, 3, -1, 0, 1, 2, 3};
  logic [7:0] pool[11]  = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74};
  bit         m_held[9];
  int         m_last = -1;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  function automatic int lookup(input logic [7:0] c, input bit e);
    for (int i = 0; i < 9; i++)
      if (k_code[i] == c && k_ext[i] == e) return i;
    return -1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 9; i++) m_held[i] = 1'b0;
    m_last = -1;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    if (m_brk) begin
      k = lookup(b, m_ext);
      if (k >= 0) m_held[k] = 1'b0;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      k = lookup(b, m_ext);
      if (k >= 0) begin
        m_held[k] = 1'b1;
        if (k_dir[k] >= 0) m_last = k_dir[k];
      end
      m_ext = 1'b0;
    end
  endfunction

  function automatic logic [3:0] model_dir();
    bit dh[4];
    for (int i = 0; i < 4; i++) dh[i] = 1'b0;
    for (int k = 0; k < 9; k++)
      if (m_held[k] && k_dir[k] >= 0) dh[k_dir[k]] = 1'b1;
    if (m_last >= 0 && dh[m_last]) return 4'(1 << m_last);
    for (int i = 0; i < 4; i++)
      if (dh[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 good, 1 bad parity, 2 bad stop, 3 bad start, 4 truncated (timeout)
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int mode);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (mode == 1) f[9]  = ~f[9];
    if (mode == 2) f[10] = 1'b0;
    if (mode == 3) f[0]  = 1'b1;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] b, input int mode, input string tag);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    case (mode)
      3:       send_bits(mk_frame(b, mode), 1);
      4: begin
        send_bits(mk_frame(b, 0), 5);
        repeat (TIMEOUT_CYCLES + 200) @(negedge clk);
      end
      default: send_bits(mk_frame(b, mode), 11);
    endcase
    repeat (4) @(negedge clk);
    if (mode == 0) begin
      model_byte(b);
      check_eq({tag, " valid"}, n_valid - v0, 1);
      check_eq({tag, " byte"}, last_byte, b);
      check_eq({tag, " err"}, n_err - e0, 0);
    end else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      check_eq({tag, " valid"}, n_valid - v0, 0);
      check_eq({tag, " err"}, n_err - e0, 1);
    end
    check_eq({tag, " dir"}, direction, model_dir());
    check_eq({tag, " fire"}, fire, m_held[4]);
  endtask

  initial begin
    int v0, e0, r;
    model_clear();
    repeat (5) @(negedge clk);
    check_eq("rst dir", direction, 4'b0000);
    check_eq("rst fire", fire, 0);
    check_eq("rst valid", rx_valid, 0);
    check_eq("rst byte", rx_byte, 8'h00);
    check_eq("rst err", frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    do_frame(8'h1D, 0, "W make");
    check_eq("W up", direction, 4'b0001);
    do_frame(8'hF0, 0, "F0");
    do_frame(8'h1D, 0, "W break");
    check_eq("W none", direction, 4'b0000);

    do_frame(8'hE0, 0, "E0");
    do_frame(8'h74, 0, "Right make");
    check_eq("right", direction, 4'b1000);
    do_frame(8'h1C, 0, "A make");
    check_eq("left", direction, 4'b0100);
    do_frame(8'hF0, 0, "F0");
    do_frame(8'h1C, 0, "A break");
    check_eq("back right", direction, 4'b1000);
    do_frame(8'hE0, 0, "E0");
    do_frame(8'hF0, 0, "F0");
    do_frame(8'h74, 0, "Right break");

    do_frame(8'h1D, 0, "W make");
    do_frame(8'h1B, 0, "S make");
    do_frame(8'hF0, 0, "F0");
    do_frame(8'h1B, 0, "S break");
    check_eq("W held", direction, 4'b0001);
    do_frame(8'h1B, 0, "S again");
    check_eq("S last", direction, 4'b0010);
    do_frame(8'hE0, 0, "E0");
    do_frame(8'h75, 0, "Up make");
    do_frame(8'hF0, 0, "F0");
    do_frame(8'h1B, 0, "S break");
    check_eq("up held", direction, 4'b0001);

    do_frame(8'h29, 1, "Space badpar");
    check_eq("fire low", fire, 0);
    do_frame(8'h29, 0, "Space make");
    check_eq("fire high", fire, 1);
    do_frame(8'hF0, 0, "F0");
    do_frame(8'h29, 0, "Space break");
    check_eq("fire off", fire, 0);

    do_frame(8'h1B, 4, "timeout");
    do_frame(8'h1B, 0, "S after timeout");

    // Glitch on the PS/2 clock shorter than the filter window.
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch err", n_err - e0, 0);
    check_eq("glitch valid", n_valid - v0, 0);
    do_frame(8'h1D, 0, "after glitch");

    // Asynchronous reset in the middle of a frame.
    do_frame(8'h29, 0, "Space make");
    send_bits(mk_frame(8'h1C, 0), 5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst dir", direction, 4'b0000);
    check_eq("midrst fire", fire, 0);
    check_eq("midrst valid", rx_valid, 0);
    check_eq("midrst err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (5) @(negedge clk);
    do_frame(8'h1B, 0, "after rst");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        do_frame(8'($urandom), int'($urandom_range(1, 3)), "rand err");
      end else begin
        r = $urandom_range(0, 14);
        if (r <= 10)      do_frame(pool[r], 0, "rand key");
        else if (r == 11) do_frame(8'($urandom), 0, "rand byte");
        else if (r == 12) do_frame(8'hE1, 0, "rand E1");
        else              do_frame(8'hF0, 0, "rand F0");
      end
    end

    check_eq("onehot", multihot, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
